// File: rtl/md_pkg.sv
// Shared encodings and default latencies for the HI/LO multiply/divide unit.
package md_pkg;
    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;
endpackage

// File: rtl/md_arith.sv
// Combinational 32x32 multiply and divide, signed or unsigned by md_op.
module md_arith
    import md_pkg::*;
(
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_zero
);
    logic        sgn;
    logic        is_div;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] mag_q;
    logic [31:0] mag_r;
    logic [31:0] quo;
    logic [31:0] rem;

    always_comb begin
        sgn    = (md_op == MD_MULT) || (md_op == MD_DIV);
        is_div = (md_op == MD_DIV) || (md_op == MD_DIVU);
        ext_a  = sgn ? {{32{a[31]}}, a} : {32'b0, a};
        ext_b  = sgn ? {{32{b[31]}}, b} : {32'b0, b};
        prod   = ext_a * ext_b;

        // Divide on magnitudes; 0x80000000 stays 0x80000000 as unsigned, so
        // the MIN/-1 case wraps without special handling.
        div_zero = (b == 32'd0);
        mag_a    = (sgn && a[31]) ? -a : a;
        mag_b    = (sgn && b[31]) ? -b : b;
        mag_q    = div_zero ? 32'd0 : mag_a / mag_b;
        mag_r    = div_zero ? 32'd0 : mag_a % mag_b;
        quo      = (sgn && (a[31] ^ b[31])) ? -mag_q : mag_q;
        rem      = (sgn && a[31]) ? -mag_r : mag_r;

        res_hi = is_div ? rem : prod[63:32];
        res_lo = is_div ? quo : prod[31:0];
    end
endmodule

// File: rtl/mult_div_unit.sv
// HI/LO unit: result computed at accept, held for a fixed busy latency,
// then committed to HI/LO on the busy-falling edge.
module mult_div_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        md_pend,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic [31:0]      res_hi_q, res_hi_d, res_lo_q, res_lo_d;
    logic             res_wr_q, res_wr_d;

    logic [31:0] ar_hi, ar_lo;
    logic        ar_div_zero;

    md_arith u_arith (
        .md_op   (md_op),
        .a       (A),
        .b       (B),
        .res_hi  (ar_hi),
        .res_lo  (ar_lo),
        .div_zero(ar_div_zero)
    );

    always_comb begin
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        res_wr_d = res_wr_q;

        if (busy_q) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
                if (res_wr_q) begin
                    hi_d = res_hi_q;
                    lo_d = res_lo_q;
                end
            end
        end else if (start) begin
            case (md_op)
                MD_MULT, MD_MULTU: begin
                    busy_d   = 1'b1;
                    cnt_d    = CNT_W'(MULT_CYCLES);
                    res_hi_d = ar_hi;
                    res_lo_d = ar_lo;
                    res_wr_d = 1'b1;
                end
                MD_DIV, MD_DIVU: begin
                    busy_d   = 1'b1;
                    cnt_d    = CNT_W'(DIV_CYCLES);
                    res_hi_d = ar_hi;
                    res_lo_d = ar_lo;
                    // Divide by zero still occupies the unit but leaves HI/LO alone.
                    res_wr_d = !ar_div_zero;
                end
                MD_MTHI: hi_d = A;
                MD_MTLO: lo_d = A;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            res_wr_q <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            res_wr_q <= res_wr_d;
        end
    end

    assign busy    = busy_q;
    assign md_pend = busy_q | (start & ~md_op[2]);
    assign hi      = hi_q;
    assign lo      = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO queued at issue, checked at completion.
module tb_mult_div_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A, B;
    logic        busy, md_pend;
    logic [31:0] hi, lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mh, ml;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    mult_div_unit dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .md_op  (md_op),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .md_pend(md_pend),
        .hi     (hi),
        .lo     (lo)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] cur_hi, input logic [31:0] cur_lo);
        exp_t            e;
        longint          sp;
        longint unsigned up;
        int              sq, sr;
        e.hi = cur_hi;
        e.lo = cur_lo;
        case (op)
            3'd0: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                e.hi = sp[63:32];
                e.lo = sp[31:0];
            end
            3'd1: begin
                up = {32'b0, a} * {32'b0, b};
                e.hi = up[63:32];
                e.lo = up[31:0];
            end
            3'd2: if (b != 0) begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.hi = 32'h0;
                    e.lo = 32'h8000_0000;
                end else begin
                    sq = $signed(a) / $signed(b);
                    sr = $signed(a) % $signed(b);
                    e.hi = sr;
                    e.lo = sq;
                end
            end
            3'd3: if (b != 0) begin
                e.hi = a % b;
                e.lo = a / b;
            end
            3'd4: e.hi = a;
            3'd5: e.lo = a;
            default: ;
        endcase
        return e;
    endfunction

    // Issue one op; with noise set, keep asserting start with noise_op during busy.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic noise, input logic [2:0] noise_op);
        exp_t e;
        int   cyc;
        int   exp_cyc;
        e = model(op, a, b, mh, ml);
        exp_q.push_back(e);
        exp_cyc = (op < 3'd2) ? 5 : (op < 3'd4) ? 10 : 0;
        @(negedge clk);
        start = 1'b1; md_op = op; A = a; B = b;
        @(negedge clk);
        cyc = 0;
        while (busy === 1'b1 && cyc < 64) begin
            cyc++;
            if (md_pend !== 1'b1) chk({tag, "_pend"}, {63'b0, md_pend}, 64'd1);
            if (noise) begin
                start = 1'b1; md_op = noise_op; A = $urandom; B = $urandom;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, "_cyc"}, 64'(cyc), 64'(exp_cyc));
        chk({tag, "_busy_done"}, {63'b0, busy}, 64'd0);
        e = exp_q.pop_front();
        chk({tag, "_hilo"}, {hi, lo}, {e.hi, e.lo});
        mh = e.hi;
        ml = e.lo;
    endtask

    initial begin
        exp_t e;
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        reset = 1'b1; start = 1'b0; md_op = '0; A = '0; B = '0;
        mh = '0; ml = '0;
        repeat (3) @(negedge clk);
        chk("rst_hilo", {hi, lo}, 64'd0);
        chk("rst_busy", {62'b0, busy, md_pend}, 64'd0);
        reset = 1'b0;

        // md_pend is combinational on start/op while idle
        @(negedge clk);
        start = 1'b1; md_op = 3'd0; #1;
        chk("pend_mult_idle", {63'b0, md_pend}, 64'd1);
        md_op = 3'd4; #1;
        chk("pend_mthi_idle", {63'b0, md_pend}, 64'd0);
        start = 1'b0;

        run_op("mult",  3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, 3'd0);
        chk("mult_exact", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 3'd0);
        chk("multu_exact", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
        run_op("div",   3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 3'd0);
        chk("div_exact", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        run_op("mthi11", 3'd4, 32'h11, 32'd0, 1'b0, 3'd0);
        run_op("mtlo22", 3'd5, 32'h22, 32'd0, 1'b0, 3'd0);
        run_op("divu0",  3'd3, 32'd100, 32'd0, 1'b0, 3'd0);
        chk("divu0_exact", {hi, lo}, 64'h0000_0011_0000_0022);

        run_op("mthi", 3'd4, 32'h1234, 32'd0, 1'b0, 3'd0);
        chk("mthi_exact", {32'b0, hi}, 64'h1234);
        run_op("rsvd", 3'd6, 32'hDEAD, 32'hBEEF, 1'b0, 3'd0);
        run_op("ovf",  3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 3'd0);
        chk("ovf_exact", {hi, lo}, 64'h0000_0000_8000_0000);

        // starts during busy (including the falling cycle) must be ignored
        run_op("mult_noise", 3'd0, 32'd1000, 32'hFFFF_FFF0, 1'b1, 3'd2);
        run_op("div_mtlo",   3'd2, 32'd77, 32'd5, 1'b1, 3'd5);
        run_op("divu_mthi",  3'd3, 32'hF000_0000, 32'd3, 1'b1, 3'd4);

        // reset during busy cycle 4 of a DIV
        e = model(3'd2, 32'd500, 32'd7, mh, ml);
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b1; md_op = 3'd2; A = 32'd500; B = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_busy_pre", {63'b0, busy}, 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        void'(exp_q.pop_back());
        mh = '0; ml = '0;
        chk("abort_busy", {63'b0, busy}, 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        repeat (12) @(negedge clk);
        chk("abort_hold", {hi, lo}, 64'd0);

        for (int i = 0; i < 8; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i == 5) ? 32'd0 : ((i % 2) ? $urandom : 32'($urandom_range(1, 300)));
            if (i % 3 == 0) ra = -ra;
            run_op("rand", rop, ra, rb, (i % 2) == 1, 3'($urandom_range(0, 7)));
        end

        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
